ram_arbiter: RTL

Two-requester arbiter that shares the single data RAM (one read or one write per cycle, 1-cycle registered read latency) between master 0 (instruction fetch) and master 1 (load/store).
- Round-robin by default.
- Supports locked bursts of up to MAX_BURST cycles.
- Routes read data back with a registered valid strobe.
- Sits between the pipeline memory stages and the RAM.

---
 rtl/ram_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port data RAM.
// Supports locked bursts and returns read data with a registered valid strobe.
module ram_arbiter #(
   parameter int AWIDTH    = 8,
   parameter int DWIDTH    = 16,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_m0_req,
   input  logic              i_m0_we,
   input  logic              i_m0_lock,
   input  logic [AWIDTH-1:0] i_m0_addr,
   input  logic [DWIDTH-1:0] i_m0_wdata,
   input  logic              i_m1_req,
   input  logic              i_m1_we,
   input  logic              i_m1_lock,
   input  logic [AWIDTH-1:0] i_m1_addr,
   input  logic [DWIDTH-1:0] i_m1_wdata,
   output logic              o_m0_gnt,
   output logic              o_m1_gnt,
   output logic              o_m0_rvalid,
   output logic              o_m1_rvalid,
   output logic [DWIDTH-1:0] o_m0_rdata,
   output logic [DWIDTH-1:0] o_m1_rdata,
   output logic              o_ram_rd,
   output logic              o_ram_wr,
   output logic [AWIDTH-1:0] o_ram_raddr,
   output logic [AWIDTH-1:0] o_ram_waddr,
   output logic [DWIDTH-1:0] o_ram_wdata,
   input  logic [DWIDTH-1:0] i_ram_rdata
);

   localparam int             CW      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CW-1:0]  LAST    = CW'(MAX_BURST - 1);
   localparam logic           LOCK_EN = 1'(MAX_BURST > 1);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t        r_state, w_nstate;
   logic          r_last, w_nlast;
   logic [CW-1:0] r_cnt, w_ncnt;
   logic          r_rv0, r_rv1;
   logic          w_gnt0, w_gnt1, w_any, w_we;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
         r_cnt   <= '0;
         r_rv0   <= 1'b0;
         r_rv1   <= 1'b0;
      end else begin
         r_state <= w_nstate;
         r_last  <= w_nlast;
         r_cnt   <= w_ncnt;
         r_rv0   <= w_gnt0 & ~i_m0_we;
         r_rv1   <= w_gnt1 & ~i_m1_we;
      end
   end

   // The burst counter runs whether or not the owner is granted, so an idle owner still times out.
   always_comb begin
      w_nstate = r_state;
      w_nlast  = r_last;
      w_ncnt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_gnt0) begin
               w_nlast = 1'b0;
               if (i_m0_lock && LOCK_EN) begin
                  w_nstate = OWN0;
                  w_ncnt   = CW'(1);
               end
            end else if (w_gnt1) begin
               w_nlast = 1'b1;
               if (i_m1_lock && LOCK_EN) begin
                  w_nstate = OWN1;
                  w_ncnt   = CW'(1);
               end
            end
         end
         OWN0: begin
            w_ncnt = r_cnt + CW'(1);
            if (!i_m0_lock || r_cnt == LAST) begin
               w_nstate = IDLE;
               w_nlast  = 1'b0;
               w_ncnt   = '0;
            end
         end
         OWN1: begin
            w_ncnt = r_cnt + CW'(1);
            if (!i_m1_lock || r_cnt == LAST) begin
               w_nstate = IDLE;
               w_nlast  = 1'b1;
               w_ncnt   = '0;
            end
         end
         default: w_nstate = IDLE;
      endcase
   end

   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (rst) begin
         case (r_state)
            IDLE: begin
               if (i_m0_req && (!i_m1_req || r_last)) w_gnt0 = 1'b1;
               else if (i_m1_req)                     w_gnt1 = 1'b1;
            end
            OWN0:    w_gnt0 = i_m0_req;
            OWN1:    w_gnt1 = i_m1_req;
            default: ;
         endcase
      end
   end

   assign w_any = w_gnt0 | w_gnt1;
   assign w_we  = w_gnt1 ? i_m1_we : i_m0_we;

   assign o_m0_gnt    = w_gnt0;
   assign o_m1_gnt    = w_gnt1;
   assign o_ram_rd    = w_any & ~w_we;
   assign o_ram_wr    = w_any & w_we;
   assign o_ram_raddr = w_gnt1 ? i_m1_addr  : (w_gnt0 ? i_m0_addr  : '0);
   assign o_ram_waddr = o_ram_raddr;
   assign o_ram_wdata = w_gnt1 ? i_m1_wdata : (w_gnt0 ? i_m0_wdata : '0);

   // A read strobe already in flight is hidden while reset is held.
   assign o_m0_rvalid = r_rv0 & rst;
   assign o_m1_rvalid = r_rv1 & rst;
   assign o_m0_rdata  = i_ram_rdata;
   assign o_m1_rdata  = i_ram_rdata;

endmodule
